// File: rtl/execute_memory_reg.sv
// ---------------------------------------------------------------------------
// execute_memory_reg
//
// Pipeline register between the execute (E) and memory (M) stages.
//
// For every live E instruction it picks the ALU result or the multiplier
// result and registers it, with pc / destination / write enable, into the
// M-stage entry. Multiplies are iterative. While one runs, E (and everything
// upstream) is held through stall_e. If the product arrives while M is
// stalled, it is parked in a one-entry hold buffer and released when M
// frees up. A saturating counter records the cycles lost waiting on the
// multiplier.
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   valid_e         E holds a live instruction
//   is_mul_e        E instruction is MUL / MULW
//   pc_e, dst_e,
//   wen_e, alu_e    E instruction fields and ALU result
//   c_mul, done_mul multiplier result and its valid strobe
//   flush_e         squash the E instruction
//   stall_m         M cannot accept this cycle (M entry holds)
//   stall_e         hold E and upstream stages
//   valid_m, pc_m,
//   dst_m, wen_m,
//   res_m           registered M-stage entry
//   fwd_valid       M entry may be forwarded (live, writes, dst != x0)
//   mul_stall_cnt   saturating count of multiply-wait cycles
// ---------------------------------------------------------------------------
module execute_memory_reg #(
   parameter int XLEN = 64,
   parameter int REGW = 5,
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_e,
   input  logic            is_mul_e,
   input  logic [XLEN-1:0] pc_e,
   input  logic [REGW-1:0] dst_e,
   input  logic            wen_e,
   input  logic [XLEN-1:0] alu_e,
   input  logic [XLEN-1:0] c_mul,
   input  logic            done_mul,
   input  logic            flush_e,
   input  logic            stall_m,
   output logic            stall_e,
   output logic            valid_m,
   output logic [XLEN-1:0] pc_m,
   output logic [REGW-1:0] dst_m,
   output logic            wen_m,
   output logic [XLEN-1:0] res_m,
   output logic            fwd_valid,
   output logic [CNTW-1:0] mul_stall_cnt
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MUL_WAIT = 2'd1;
   localparam logic [1:0] MUL_HOLD = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [REGW-1:0] dst;
      logic            wen;
      logic [XLEN-1:0] res;
   } entry_t;

   logic [1:0]      state_q, state_d;
   logic            valid_q;
   entry_t          m_q;
   entry_t          hold_q;
   logic [CNTW-1:0] cnt_q;

   logic            load_valid;
   entry_t          load_d;
   logic            hold_we;
   logic            cnt_inc;
   logic            stall_int;
   logic            mul_enter;
   entry_t          alu_entry;
   entry_t          mul_entry;

   // A multiply in E only starts a wait when it is not being squashed.
   assign mul_enter = valid_e & is_mul_e & ~flush_e;

   always_comb begin
      alu_entry.pc  = pc_e;
      alu_entry.dst = dst_e;
      alu_entry.wen = wen_e;
      alu_entry.res = alu_e;

      // E is held during the wait, so its pc/dst/wen still describe the
      // multiply when the product arrives.
      mul_entry.pc  = pc_e;
      mul_entry.dst = dst_e;
      mul_entry.wen = wen_e;
      mul_entry.res = c_mul;
   end

   // Next-state / next-entry selection. Whatever is chosen here only reaches
   // the M register when stall_m is low; otherwise the M entry holds.
   // load_valid = 0 means "load a bubble".
   always_comb begin
      state_d    = state_q;
      load_valid = 1'b0;
      load_d     = '0;
      hold_we    = 1'b0;
      cnt_inc    = 1'b0;
      stall_int  = stall_m;

      case (state_q)
         RUN: begin
            if (mul_enter) begin
               // done_mul is ignored here: it still reflects the previous,
               // idle multiplier state.
               state_d   = MUL_WAIT;
               stall_int = 1'b1;
               cnt_inc   = 1'b1;
            end else if (valid_e & ~flush_e) begin
               load_valid = 1'b1;
               load_d     = alu_entry;
            end
         end

         MUL_WAIT: begin
            stall_int = 1'b1;
            if (flush_e) begin
               // The multiplier sees the same flush and aborts on its own.
               state_d = RUN;
               cnt_inc = ~done_mul;
            end else if (done_mul) begin
               if (stall_m) begin
                  hold_we = 1'b1;
                  state_d = MUL_HOLD;
               end else begin
                  // Release E on the same edge the product is written, so
                  // the multiply is not seen again in RUN.
                  state_d    = RUN;
                  load_valid = 1'b1;
                  load_d     = mul_entry;
                  stall_int  = 1'b0;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end

         MUL_HOLD: begin
            // Instruction already complete: flush_e, c_mul and done_mul are
            // irrelevant. E is released together with the buffered write.
            stall_int = 1'b1;
            if (!stall_m) begin
               state_d    = RUN;
               load_valid = 1'b1;
               load_d     = hold_q;
               stall_int  = 1'b0;
            end
         end

         default: state_d = RUN;
      endcase
   end

   // stall_e is forced low while reset is held.
   assign stall_e = reset & stall_int;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         valid_q <= 1'b0;
         m_q     <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (!stall_m) begin
            valid_q <= load_valid;
            m_q     <= load_d;
         end
         if (hold_we)
            hold_q <= mul_entry;
         // Saturate at all-ones rather than wrap.
         if (cnt_inc && (cnt_q != '1))
            cnt_q <= cnt_q + CNTW'(1);
      end
   end

   assign valid_m       = valid_q;
   assign pc_m          = m_q.pc;
   assign dst_m         = m_q.dst;
   assign wen_m         = m_q.wen;
   assign res_m         = m_q.res;
   assign fwd_valid     = valid_q & m_q.wen & (m_q.dst != '0);
   assign mul_stall_cnt = cnt_q;

endmodule

// File: tb/tb_execute_memory_reg.sv
module tb_execute_memory_reg;

   logic        clk = 1'b0;
   logic        clk_en = 1'b1;
   logic        reset;
   logic        valid_e, is_mul_e, wen_e, done_mul, flush_e, stall_m;
   logic [63:0] pc_e, alu_e, c_mul;
   logic [4:0]  dst_e;

   logic        stall_e, valid_m, wen_m, fwd_valid;
   logic [63:0] pc_m, res_m;
   logic [4:0]  dst_m;
   logic [31:0] cnt;

   logic        s_stall_e, s_valid_m, s_wen_m, s_fwd_valid;
   logic [63:0] s_pc_m, s_res_m;
   logic [4:0]  s_dst_m;
   logic [3:0]  cnt4;

   int n_chk = 0;
   int n_fail = 0;

   always #5 if (clk_en) clk = ~clk;

   execute_memory_reg #(.XLEN(64), .REGW(5), .CNTW(32)) dut (
      .clk(clk), .reset(reset), .valid_e(valid_e), .is_mul_e(is_mul_e),
      .pc_e(pc_e), .dst_e(dst_e), .wen_e(wen_e), .alu_e(alu_e),
      .c_mul(c_mul), .done_mul(done_mul), .flush_e(flush_e), .stall_m(stall_m),
      .stall_e(stall_e), .valid_m(valid_m), .pc_m(pc_m), .dst_m(dst_m),
      .wen_m(wen_m), .res_m(res_m), .fwd_valid(fwd_valid), .mul_stall_cnt(cnt));

   execute_memory_reg #(.XLEN(64), .REGW(5), .CNTW(4)) dut4 (
      .clk(clk), .reset(reset), .valid_e(valid_e), .is_mul_e(is_mul_e),
      .pc_e(pc_e), .dst_e(dst_e), .wen_e(wen_e), .alu_e(alu_e),
      .c_mul(c_mul), .done_mul(done_mul), .flush_e(flush_e), .stall_m(stall_m),
      .stall_e(s_stall_e), .valid_m(s_valid_m), .pc_m(s_pc_m), .dst_m(s_dst_m),
      .wen_m(s_wen_m), .res_m(s_res_m), .fwd_valid(s_fwd_valid), .mul_stall_cnt(cnt4));

   typedef struct {
      logic v, m, f, sm, dn, wen;
      logic [63:0] pc, alu, cm;
      logic [4:0]  dst;
      logic e_se, e_vm, e_fwd;
      logic [63:0] e_res;
      logic [4:0]  e_dst;
   } vec_t;

   vec_t tbl[8];

   function automatic vec_t mk(input logic v, m, f, sm, dn, input logic [63:0] pc,
                               input logic [4:0] dst, input logic wen,
                               input logic [63:0] alu, cm, input logic e_se, e_vm,
                               input logic [63:0] e_res, input logic [4:0] e_dst,
                               input logic e_fwd);
      vec_t r;
      r.v = v; r.m = m; r.f = f; r.sm = sm; r.dn = dn; r.pc = pc; r.dst = dst;
      r.wen = wen; r.alu = alu; r.cm = cm; r.e_se = e_se; r.e_vm = e_vm;
      r.e_res = e_res; r.e_dst = e_dst; r.e_fwd = e_fwd;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, m, f, sm, dn, input logic [63:0] pc,
                        input logic [4:0] dst, input logic wen, input logic [63:0] alu, cm);
      valid_e = v; is_mul_e = m; flush_e = f; stall_m = sm; done_mul = dn;
      pc_e = pc; dst_e = dst; wen_e = wen; alu_e = alu; c_mul = cm;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset with the clock running; returns at posedge+1 with idle inputs.
   task automatic do_reset();
      idle();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   // ---------------- reference model ----------------
   // A multiply is "outstanding" until its product appears (or it is
   // flushed); a finished product that M cannot take waits in a queue.
   bit          busy;
   logic [63:0] q_pc[$], q_res[$];
   logic [4:0]  q_dst[$];
   logic        q_wen[$];
   logic        r_v, r_wen;
   logic [63:0] r_pc, r_res;
   logic [4:0]  r_dst;
   longint      raw_waits;

   task automatic model_reset();
      busy = 0; q_pc.delete(); q_res.delete(); q_dst.delete(); q_wen.delete();
      r_v = 0; r_wen = 0; r_pc = 0; r_res = 0; r_dst = 0; raw_waits = 0;
   endtask

   task automatic model_step(output logic se);
      logic nv, nwen;
      logic [63:0] npc, nres;
      logic [4:0] ndst;
      nv = 0; nwen = 0; npc = 0; nres = 0; ndst = 0;
      if (q_pc.size() != 0) begin
         se = stall_m;
         if (!stall_m) begin
            nv = 1; npc = q_pc.pop_front(); nres = q_res.pop_front();
            ndst = q_dst.pop_front(); nwen = q_wen.pop_front();
         end
      end else if (busy) begin
         if (flush_e) begin
            se = 1; busy = 0;
            if (!done_mul) raw_waits++;
         end else if (done_mul) begin
            busy = 0; se = stall_m;
            if (stall_m) begin
               q_pc.push_back(pc_e); q_res.push_back(c_mul);
               q_dst.push_back(dst_e); q_wen.push_back(wen_e);
            end else begin
               nv = 1; npc = pc_e; nres = c_mul; ndst = dst_e; nwen = wen_e;
            end
         end else begin
            se = 1; raw_waits++;
         end
      end else if (valid_e && is_mul_e && !flush_e) begin
         se = 1; busy = 1; raw_waits++;
      end else begin
         se = stall_m;
         if (valid_e && !flush_e) begin
            nv = 1; npc = pc_e; nres = alu_e; ndst = dst_e; nwen = wen_e;
         end
      end
      if (!stall_m) begin
         r_v = nv; r_pc = npc; r_res = nres; r_dst = ndst; r_wen = nwen;
      end
   endtask

   initial begin
      int hi;
      logic exp_se;
      longint e4;

      // ---------------- reset state ----------------
      reset = 1'b0;
      drive(1, 1, 0, 0, 1, 64'h40, 5'd2, 1, 64'h9, 64'h9);
      #12;
      check("rst valid_m", valid_m, 0);
      check("rst res_m", res_m, 0);
      check("rst pc_m", pc_m, 0);
      check("rst dst_m", dst_m, 0);
      check("rst wen_m", wen_m, 0);
      check("rst fwd", fwd_valid, 0);
      check("rst cnt", cnt, 0);
      check("rst stall_e", stall_e, 0);
      @(negedge clk);
      reset = 1'b1;
      idle();
      tick();

      // ---------------- table-driven vectors ----------------
      //          v m f sm dn pc      dst  wen alu    cm        se vm res      dst fwd
      tbl[0] = mk(1,0,0,0,0, 64'h100, 5'd3, 1, 64'h5, 64'h0,     0, 1, 64'h5,  5'd3, 1);
      tbl[1] = mk(1,0,0,1,0, 64'h104, 5'd4, 1, 64'h7, 64'h0,     1, 1, 64'h5,  5'd3, 1);
      tbl[2] = mk(1,0,0,0,0, 64'h104, 5'd4, 1, 64'h7, 64'h0,     0, 1, 64'h7,  5'd4, 1);
      tbl[3] = mk(1,0,1,0,0, 64'h108, 5'd5, 1, 64'h9, 64'h0,     0, 0, 64'h0,  5'd0, 0);
      tbl[4] = mk(1,1,0,0,1, 64'h110, 5'd6, 1, 64'h0, 64'hdead,  1, 0, 64'h0,  5'd0, 0);
      tbl[5] = mk(1,1,0,0,0, 64'h110, 5'd6, 1, 64'h0, 64'h0,     1, 0, 64'h0,  5'd0, 0);
      tbl[6] = mk(1,1,0,0,1, 64'h110, 5'd6, 1, 64'h0, 64'h21,    0, 1, 64'h21, 5'd6, 1);
      tbl[7] = mk(1,0,0,0,0, 64'h114, 5'd0, 1, 64'h3, 64'h0,     0, 1, 64'h3,  5'd0, 0);
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].v, tbl[i].m, tbl[i].f, tbl[i].sm, tbl[i].dn, tbl[i].pc,
               tbl[i].dst, tbl[i].wen, tbl[i].alu, tbl[i].cm);
         #1;
         check($sformatf("tbl%0d stall_e", i), stall_e, tbl[i].e_se);
         tick();
         check($sformatf("tbl%0d valid_m", i), valid_m, tbl[i].e_vm);
         check($sformatf("tbl%0d res_m", i), res_m, tbl[i].e_res);
         check($sformatf("tbl%0d dst_m", i), dst_m, tbl[i].e_dst);
         check($sformatf("tbl%0d fwd", i), fwd_valid, tbl[i].e_fwd);
      end
      check("tbl cnt", cnt, 2);

      // ---------------- long multiply ----------------
      hi = 0;
      drive(1, 1, 0, 0, 0, 64'h200, 5'd7, 1, 0, 0);
      #1 if (stall_e) hi++;
      tick();
      for (int i = 0; i < 64; i++) begin
         drive(1, 1, 0, 0, 0, 64'h200, 5'd7, 1, 0, 0);
         #1 if (stall_e) hi++;
         tick();
         check("mul64 bubble", valid_m, 0);
      end
      drive(1, 1, 0, 0, 1, 64'h200, 5'd7, 1, 0, 64'h12);
      #1 check("mul64 done stall_e", stall_e, 0);
      tick();
      check("mul64 stall cycles", hi, 65);
      check("mul64 valid_m", valid_m, 1);
      check("mul64 res_m", res_m, 64'h12);
      check("mul64 cnt", cnt, 67);
      idle();
      tick();

      // ---------------- product arrives while M stalled ----------------
      drive(1, 1, 0, 0, 0, 64'h300, 5'd8, 1, 0, 0);
      #1 check("hold entry stall_e", stall_e, 1);
      tick();
      drive(1, 1, 0, 1, 1, 64'h300, 5'd8, 1, 0, 64'hABCD);
      #1 check("hold done stall_e", stall_e, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 1, 0, 64'h300, 5'd8, 1, 0, 0);
         #1 check("hold stall_e", stall_e, 1);
         tick();
         check("hold valid_m", valid_m, 0);
      end
      drive(1, 1, 0, 0, 0, 64'h300, 5'd8, 1, 0, 0);
      #1 check("hold release stall_e", stall_e, 0);
      tick();
      check("hold valid_m out", valid_m, 1);
      check("hold res_m", res_m, 64'hABCD);
      check("hold pc_m", pc_m, 64'h300);
      check("hold dst_m", dst_m, 8);
      check("hold cnt", cnt, 68);
      idle();
      tick();

      // ---------------- flush during wait ----------------
      drive(1, 1, 0, 0, 0, 64'h400, 5'd9, 1, 0, 0);
      tick();
      drive(1, 1, 0, 0, 0, 64'h400, 5'd9, 1, 0, 0);
      tick();
      drive(1, 1, 1, 0, 0, 64'h400, 5'd9, 1, 0, 0);
      #1 check("flush stall_e", stall_e, 1);
      tick();
      check("flush valid_m", valid_m, 0);
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 64'hBAD);
      #1 check("flush after stall_e", stall_e, 0);
      tick();
      check("flush no late write", valid_m, 0);
      check("flush res_m", res_m, 0);
      check("flush cnt", cnt, 71);

      // ---------------- async reset, clock stopped, mid-wait ----------------
      drive(1, 0, 0, 0, 0, 64'h500, 5'd10, 1, 64'h77, 0);
      tick();
      check("ar add valid_m", valid_m, 1);
      drive(1, 1, 0, 1, 0, 64'h504, 5'd11, 1, 0, 0);
      tick();
      check("ar held valid_m", valid_m, 1);
      check("ar held res_m", res_m, 64'h77);
      clk_en = 1'b0;
      #3 reset = 1'b0;
      #1;
      check("ar valid_m", valid_m, 0);
      check("ar res_m", res_m, 0);
      check("ar pc_m", pc_m, 0);
      check("ar dst_m", dst_m, 0);
      check("ar cnt", cnt, 0);
      check("ar stall_e", stall_e, 0);
      #5 reset = 1'b1;
      #2 clk_en = 1'b1;
      drive(1, 0, 0, 0, 0, 64'h600, 5'd3, 1, 64'h5, 0);
      #1 check("ar2 stall_e", stall_e, 0);
      tick();
      check("ar2 valid_m", valid_m, 1);
      check("ar2 res_m", res_m, 5);
      check("ar2 dst_m", dst_m, 3);
      check("ar2 fwd", fwd_valid, 1);
      check("ar2 cnt", cnt, 0);

      // ---------------- counter saturation (CNTW = 4) ----------------
      do_reset();
      drive(1, 1, 0, 0, 0, 64'h700, 5'd12, 1, 0, 0);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 0, 0, 0, 64'h700, 5'd12, 1, 0, 0);
         tick();
      end
      check("sat cnt4", cnt4, 15);
      check("sat cnt32", cnt, 21);
      drive(1, 1, 0, 0, 1, 64'h700, 5'd12, 1, 0, 64'h5);
      tick();
      check("sat cnt4 done", cnt4, 15);
      check("sat res4", s_res_m, 5);

      // ---------------- randomized vs reference model ----------------
      do_reset();
      model_reset();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(99) < 80, $urandom_range(99) < 25,
               $urandom_range(99) < 8, $urandom_range(99) < 30,
               $urandom_range(99) < 30,
               {32'h0, $urandom}, 5'($urandom_range(31)), 1'($urandom_range(1)),
               {$urandom, $urandom}, {$urandom, $urandom});
         #1;
         model_step(exp_se);
         check("rnd stall_e", stall_e, exp_se);
         check("rnd stall_e4", s_stall_e, exp_se);
         tick();
         e4 = (raw_waits > 15) ? 15 : raw_waits;
         check("rnd valid_m", valid_m, r_v);
         check("rnd pc_m", pc_m, r_pc);
         check("rnd dst_m", dst_m, r_dst);
         check("rnd wen_m", wen_m, r_wen);
         check("rnd res_m", res_m, r_res);
         check("rnd fwd", fwd_valid, r_v & r_wen & (r_dst != 0));
         check("rnd cnt", cnt, raw_waits[31:0]);
         check("rnd cnt4", cnt4, e4[3:0]);
         check("rnd s_valid_m", s_valid_m, r_v);
         check("rnd s_pc_m", s_pc_m, r_pc);
         check("rnd s_dst_m", s_dst_m, r_dst);
         check("rnd s_wen_m", s_wen_m, r_wen);
         check("rnd s_res_m", s_res_m, r_res);
         check("rnd s_fwd", s_fwd_valid, r_v & r_wen & (r_dst != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
